// File: rtl/rv32i_mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) in front of a single-port memory.
// One transaction outstanding; data has priority, bounded by a fetch starvation streak.
module rv32i_mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);
    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t        r_state, w_next;
    logic          r_own_d;
    logic          r_done;
    logic [SW-1:0] r_streak;
    logic          w_pick_if, w_pick_d, w_rsp;

    // Fetch wins when data is absent or when data has starved it for STREAK_MAX grants.
    assign w_pick_if = if_req && (!d_req || r_streak == SMAX);
    assign w_pick_d  = d_req && !w_pick_if;
    // r_done keeps the FSM in RESP during the rvalid cycle so no grant overlaps it.
    assign w_rsp     = (r_state == S_RESP) && mem_rvalid && !r_done;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (if_gnt || d_gnt) w_next = S_ISSUE;
            S_ISSUE: if (mem_gnt)         w_next = S_RESP;
            S_RESP:  if (r_done)          w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        busy   = (r_state != S_IDLE);
        if (r_state == S_IDLE && !reset) begin
            if_gnt = w_pick_if;
            d_gnt  = w_pick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_own_d   <= 1'b0;
            r_done    <= 1'b0;
            r_streak  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (if_gnt || d_gnt) begin
                r_own_d   <= d_gnt;
                mem_req   <= 1'b1;
                mem_we    <= d_gnt && d_we;
                mem_addr  <= (d_gnt ? d_addr : if_addr) & ~XLEN'(3);
                mem_wdata <= d_gnt ? d_wdata : '0;
            end else if (r_state == S_ISSUE && mem_gnt) begin
                mem_req <= 1'b0;
            end

            if (!if_req || if_gnt)
                r_streak <= '0;
            else if (d_gnt && r_streak != SMAX)
                r_streak <= r_streak + 1'b1;

            r_done    <= w_rsp;
            if_rvalid <= w_rsp && !r_own_d;
            d_rvalid  <= w_rsp && r_own_d;
            if (w_rsp && !r_own_d) if_rdata <= mem_rdata;
            if (w_rsp && r_own_d)  d_rdata  <= mem_we ? '0 : mem_rdata;
        end
    end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: per-cycle vector table plus
// hand sequences for starvation, backpressure and reset mid-transaction.
module tb_rv32i_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int n_chk = 0;
    int n_fail = 0;

    rv32i_mem_arbiter #(.XLEN(32), .STREAK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // ctl = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy}
    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr, dwe;
        logic [31:0] da, dwd;
        logic        mg, mrv;
        logic [31:0] mrd;
        logic [6:0]  ctl;
        logic [31:0] ird, drd, maddr, mwd;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t mk(logic ifr, logic [31:0] ifa, logic dr, logic dwe,
                                logic [31:0] da, logic [31:0] dwd, logic mg, logic mrv,
                                logic [31:0] mrd, logic [6:0] ctl, logic [31:0] ird,
                                logic [31:0] drd, logic [31:0] maddr, logic [31:0] mwd);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.mg = mg; v.mrv = mrv; v.mrd = mrd; v.ctl = ctl;
        v.ird = ird; v.drd = drd; v.maddr = maddr; v.mwd = mwd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctl_now();
        return {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy};
    endfunction

    logic [1:0] gq[$];
    logic [1:0] gexp[6];
    bit         done;

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0, 0, 0);
        // fetch-only, minimum latency
        tv[1]  = mk(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 7'b1000000, 0, 0, 0, 0);
        tv[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000101, 0, 0, 'h104, 0);
        tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h00500513, 7'b0000001, 0, 0, 'h104, 0);
        tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010001, 'h00500513, 0, 'h104, 0);
        tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 'h00500513, 0, 'h104, 0);
        // store to unaligned address
        tv[6]  = mk(0, 0, 1, 1, 'h203, 'hDEADBEEF, 0, 0, 0, 7'b0100000, 'h00500513, 0, 'h104, 0);
        tv[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000111, 'h00500513, 0, 'h200, 'hDEADBEEF);
        tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h12345678, 7'b0000011, 'h00500513, 0, 'h200, 'hDEADBEEF);
        tv[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001011, 'h00500513, 0, 'h200, 'hDEADBEEF);
        tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000010, 'h00500513, 0, 'h200, 'hDEADBEEF);
        // simultaneous requests: data first, fetch in the next IDLE
        tv[11] = mk(1, 'h108, 1, 0, 'h200, 0, 0, 0, 0, 7'b0100010, 'h00500513, 0, 'h200, 'hDEADBEEF);
        tv[12] = mk(1, 'h108, 0, 0, 0, 0, 1, 0, 0, 7'b0000101, 'h00500513, 0, 'h200, 0);
        tv[13] = mk(1, 'h108, 0, 0, 0, 0, 0, 1, 'hCAFEF00D, 7'b0000001, 'h00500513, 0, 'h200, 0);
        tv[14] = mk(1, 'h108, 0, 0, 0, 0, 0, 0, 0, 7'b0001001, 'h00500513, 'hCAFEF00D, 'h200, 0);
        tv[15] = mk(1, 'h108, 0, 0, 0, 0, 0, 0, 0, 7'b1000000, 'h00500513, 'hCAFEF00D, 'h200, 0);
        tv[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000101, 'h00500513, 'hCAFEF00D, 'h108, 0);
        tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 'h00000013, 7'b0000001, 'h00500513, 'hCAFEF00D, 'h108, 0);
        tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010001, 'h00000013, 'hCAFEF00D, 'h108, 0);
        // stray mem_gnt / mem_rvalid in IDLE must be ignored
        tv[19] = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hFFFFFFFF, 7'b0000000, 'h00000013, 'hCAFEF00D, 'h108, 0);
        tv[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 'h00000013, 'hCAFEF00D, 'h108, 0);

        tick();
        tick();
        for (int i = 0; i < 21; i++) begin
            tick();
            reset = 1'b0;
            if_req = tv[i].ifr; if_addr = tv[i].ifa; d_req = tv[i].dr; d_we = tv[i].dwe;
            d_addr = tv[i].da; d_wdata = tv[i].dwd; mem_gnt = tv[i].mg;
            mem_rvalid = tv[i].mrv; mem_rdata = tv[i].mrd;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  160'({ctl_now(), if_rdata, d_rdata, mem_addr, mem_wdata}),
                  160'({tv[i].ctl, tv[i].ird, tv[i].drd, tv[i].maddr, tv[i].mwd}));
        end

        // Starvation: both held, memory always ready -> D D D D I D
        tick();
        if_req = 1; if_addr = 'h300; d_req = 1; d_we = 0; d_addr = 'h400; d_wdata = 0;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 'h11110000;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) gq.push_back({if_gnt, d_gnt});
            if (gq.size() == 6) done = 1;
            else tick();
        end
        check("starve_grant_count", 160'(gq.size()), 160'(6));
        gexp[0] = 2'b01; gexp[1] = 2'b01; gexp[2] = 2'b01; gexp[3] = 2'b01;
        gexp[4] = 2'b10; gexp[5] = 2'b01;
        for (int k = 0; k < 6; k++)
            if (k < gq.size())
                check($sformatf("starve_grant%0d", k), 160'(gq[k]), 160'(gexp[k]));

        tick();
        if_req = 0; d_req = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1;
            else tick();
        end
        check("drain_idle", 160'(done), 160'(1));

        // Backpressure: mem_gnt low for 5 cycles while fetch waits
        tick();
        mem_gnt = 0; mem_rvalid = 0;
        d_req = 1; d_we = 0; d_addr = 'h512; if_req = 1; if_addr = 'h600;
        @(negedge clk);
        check("bp_grant", 160'({if_gnt, d_gnt}), 160'(2'b01));
        tick();
        d_req = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_stall%0d", k),
                  160'({mem_req, mem_addr, if_gnt, d_gnt}), 160'({1'b1, 32'h510, 2'b00}));
            tick();
        end
        mem_gnt = 1;
        @(negedge clk);
        tick();
        mem_gnt = 0;
        @(negedge clk);
        check("bp_resp_state", 160'({mem_req, busy, if_gnt}), 160'(3'b010));

        // Reset during RESP, then a late mem_rvalid
        tick();
        reset = 1; if_req = 0; d_req = 0;
        @(negedge clk);
        tick();
        reset = 0; mem_rvalid = 1; mem_rdata = 'hBAD0BAD0;
        @(negedge clk);
        check("rst_outputs",
              160'({ctl_now(), if_rdata, d_rdata, mem_addr, mem_wdata}), 160'(0));
        tick();
        mem_rvalid = 0;
        @(negedge clk);
        check("rst_late_rvalid",
              160'({if_rvalid, d_rvalid, busy, d_rdata, if_rdata}), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
